pll_reset_sequencer: RTL and testbench

//  Consumer end of the PLL: runs in the PLL output clock domain. Takes the PLL's asynchronous
//  'locked' flag and issues a clean, glitch-free system reset.

---
 rtl/pll_reset_sequencer_pkg.sv | 26 ++
 rtl/bit_synchronizer.sv | 23 ++
 rtl/pll_reset_sequencer.sv | 110 +++++++++++
 tb/tb_pll_reset_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared PLL-domain definitions: FSM state encodings and elaboration helpers.
package pll_reset_sequencer_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(value)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock and sequences the system reset; tracks lock-loss events.
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int LOSS_CNT_W    = 8
) (
    input  logic                  CLK,
    input  logic                  resetn,
    input  logic                  locked,
    input  logic                  rst_req,
    input  logic                  clr_lost,
    output logic                  sys_resetn,
    output logic                  ready,
    output logic                  lost_lock,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    localparam int CNT_W = clog2(max2(STABLE_CYCLES, HOLD_CYCLES) + 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_params
        $error("pll_reset_sequencer: illegal parameter values");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             locked_s;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (CLK),
        .clr_n (resetn),
        .d     (locked),
        .q     (locked_s)
    );

    // Loss handling sits first in each phase so it beats counter completion and rst_req.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            sys_resetn <= 1'b0;
            lost_lock  <= 1'b0;
            loss_count <= '0;
        end else begin
            if (clr_lost) begin
                lost_lock <= 1'b0;
            end
            unique case (state)
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= STABILIZE;
                        cnt   <= '0;
                    end
                end
                STABILIZE: begin
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state      <= RUN;
                        cnt        <= '0;
                        sys_resetn <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state      <= WAIT_LOCK;
                        cnt        <= '0;
                        sys_resetn <= 1'b0;
                        lost_lock  <= 1'b1;
                        if (loss_count != '1) begin
                            loss_count <= loss_count + 1'b1;
                        end
                    end else if (rst_req) begin
                        state      <= HOLD;
                        cnt        <= '0;
                        sys_resetn <= 1'b0;
                    end
                end
                default: begin
                    state      <= WAIT_LOCK;
                    cnt        <= '0;
                    sys_resetn <= 1'b0;
                end
            endcase
        end
    end

    assign ready = sys_resetn;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer with a short qualification window.
module tb_pll_reset_sequencer;

    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 8;
    localparam int HOLD_CYCLES   = 4;
    localparam int LOSS_CNT_W    = 2;

    logic                  CLK = 1'b0;
    logic                  resetn = 1'b0;
    logic                  locked = 1'b1;
    logic                  rst_req = 1'b0;
    logic                  clr_lost = 1'b0;
    logic                  sys_resetn;
    logic                  ready;
    logic                  lost_lock;
    logic [LOSS_CNT_W-1:0] loss_count;

    typedef struct {
        int                    at;
        string                 name;
        logic                  sr;
        logic                  ll;
        logic [LOSS_CNT_W-1:0] lc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .LOSS_CNT_W    (LOSS_CNT_W)
    ) dut (
        .CLK        (CLK),
        .resetn     (resetn),
        .locked     (locked),
        .rst_req    (rst_req),
        .clr_lost   (clr_lost),
        .sys_resetn (sys_resetn),
        .ready      (ready),
        .lost_lock  (lost_lock),
        .loss_count (loss_count)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic expect_at(input int ofs, input string name, input logic sr,
                             input logic ll, input logic [LOSS_CNT_W-1:0] lc);
        exp_t e;
        e.at   = cyc + ofs;
        e.name = name;
        e.sr   = sr;
        e.ll   = ll;
        e.lc   = lc;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    // Monitor: sample mid-cycle, compare every entry due at this edge count
    always @(negedge CLK) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at <= cyc) begin
                checks++;
                if (q[i].at < cyc || sys_resetn !== q[i].sr || ready !== q[i].sr ||
                    lost_lock !== q[i].ll || loss_count !== q[i].lc) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: got sr=%b rdy=%b ll=%b lc=%0d, want sr=%b ll=%b lc=%0d",
                             q[i].name, cyc, sys_resetn, ready, lost_lock, loss_count,
                             q[i].sr, q[i].ll, q[i].lc);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        int lc_exp;
        // reset state
        step(3);
        expect_at(0, "reset_state", 1'b0, 1'b0, 2'd0);
        // 1: release with lock already present
        resetn = 1'b1;
        expect_at(14, "t1_before", 1'b0, 1'b0, 2'd0);
        expect_at(15, "t1_rise", 1'b1, 1'b0, 2'd0);
        step(15);
        // 3: lock loss in RUN, then clear sticky flag
        locked = 1'b0;
        expect_at(2, "t3_still_run", 1'b1, 1'b0, 2'd0);
        expect_at(3, "t3_drop", 1'b0, 1'b1, 2'd1);
        step(3);
        clr_lost = 1'b1;
        step(1);
        clr_lost = 1'b0;
        expect_at(0, "t3_clr", 1'b0, 1'b0, 2'd1);
        // 2: glitch during STABILIZE at cnt=5 restarts qualification
        locked = 1'b1;
        step(8);
        locked = 1'b0;
        step(3);
        locked = 1'b1;
        expect_at(0, "t2_no_loss", 1'b0, 1'b0, 2'd1);
        expect_at(14, "t2_before", 1'b0, 1'b0, 2'd1);
        expect_at(15, "t2_rise", 1'b1, 1'b0, 2'd1);
        step(15);
        // 4: soft reset request in RUN
        rst_req = 1'b1;
        step(1);
        rst_req = 1'b0;
        expect_at(0, "t4_req_low", 1'b0, 1'b0, 2'd1);
        expect_at(3, "t4_hold", 1'b0, 1'b0, 2'd1);
        expect_at(4, "t4_back", 1'b1, 1'b0, 2'd1);
        step(4);
        // 5: repeated losses saturate; loss+rst_req and loss+clr_lost coincide
        for (int it = 1; it <= 5; it++) begin
            lc_exp = (1 + it > 3) ? 3 : 1 + it;
            if (it == 5) begin
                clr_lost = 1'b1;
                step(1);
                clr_lost = 1'b0;
                expect_at(0, "t5_clr_alone", 1'b1, 1'b0, 2'd3);
            end
            locked = 1'b0;
            step(2);
            if (it == 1) rst_req = 1'b1;
            if (it == 5) clr_lost = 1'b1;
            expect_at(1, $sformatf("t5_loss%0d", it), 1'b0, 1'b1, 2'(lc_exp));
            step(1);
            rst_req  = 1'b0;
            clr_lost = 1'b0;
            locked   = 1'b1;
            expect_at(14, $sformatf("t5_pre%0d", it), 1'b0, 1'b1, 2'(lc_exp));
            expect_at(15, $sformatf("t5_run%0d", it), 1'b1, 1'b1, 2'(lc_exp));
            step(15);
        end
        // 6: async reset during HOLD, then requalify with an ignored rst_req
        rst_req = 1'b1;
        step(1);
        rst_req = 1'b0;
        expect_at(0, "t6_in_hold", 1'b0, 1'b1, 2'd3);
        step(1);
        resetn = 1'b0;
        expect_at(0, "t6_async", 1'b0, 1'b0, 2'd0);
        step(2);
        resetn = 1'b1;
        expect_at(14, "t6_before", 1'b0, 1'b0, 2'd0);
        expect_at(15, "t6_rise", 1'b1, 1'b0, 2'd0);
        step(6);
        rst_req = 1'b1;
        step(1);
        rst_req = 1'b0;
        step(8);
        step(2);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending: got %0d unchecked entries, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout at cyc=%0d, want completion", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
